// File: rtl/bandai2003_pkg.sv
// Shared types and constants for the cartridge-mapper serial-out receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bandai2003_pkg;

    // Receiver frame states: waiting for start, collecting data, checking the tail.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } state_e;

    // Unlock word that sets SYSTEM_CTRL1 bit 7.
    localparam logic [15:0] MAGIC_DEFAULT = 16'h28A0;

    // Frame layout: 1 start bit + 16 data bits + 1 tail bit.
    localparam int DATA_BITS  = 16;
    localparam int FRAME_BITS = 18;
    localparam int BIT_CNT_W  = $clog2(DATA_BITS);

endpackage

// File: rtl/so_receiver.sv
// Deserialises SO frames {start 0, 16 data bits LSB-first, tail 0} into DATA and tracks the sticky CTRL1_B7 unlock bit.
// Latency: VALID/FERR pulse one cycle after the tail sample, 18 cycles after the start sample.
// Backpressure: none; one SO bit is consumed every CLK, results must be taken on the VALID pulse.
//
// Ports:
//   CLK, RSTn       clock (SO sampled on rising edge) and async active-low reset
//   SO              serial input, idle high; X/Z read as 1 (external pull-up)
//   CLR             synchronous clear of CTRL1_B7 (a coincident MAGIC frame wins)
//   DATA            last valid word received
//   VALID, FERR     one-cycle pulses: good tail / bad tail
//   CTRL1_B7        sticky, set by a valid frame equal to MAGIC
//   BUSY            high while in DATA or TAIL
module so_receiver
    import bandai2003_pkg::*;
#(
    parameter logic [15:0] MAGIC    = MAGIC_DEFAULT,
    parameter int          MIN_IDLE = 4
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        SO,
    input  logic        CLR,
    output logic [15:0] DATA,
    output logic        VALID,
    output logic        FERR,
    output logic        CTRL1_B7,
    output logic        BUSY
);

    localparam int                    IDLE_W    = (MIN_IDLE < 1) ? 1 : $clog2(MIN_IDLE + 1);
    localparam logic [IDLE_W-1:0]     IDLE_FULL = IDLE_W'(MIN_IDLE);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);

    state_e                 state_q,    state_d;
    logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [15:0]            shift_q,    shift_d;
    logic [15:0]            data_q,     data_d;
    logic                   valid_q,    valid_d;
    logic                   ferr_q,     ferr_d;
    logic                   ctrl1_b7_q, ctrl1_b7_d;
    logic                   busy_q,     busy_d;
    logic                   so_bit;

    // Only a solid 0 counts as a low bit; X and Z fall into the default arm
    // because the line is pulled up on the board.
    always_comb begin
        case (SO)
            1'b0:    so_bit = 1'b0;
            default: so_bit = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        ctrl1_b7_d = ctrl1_b7_q;

        // Clear first so a matching valid frame below overrides it.
        if (CLR) begin
            ctrl1_b7_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (so_bit) begin
                    if (idle_cnt_q != IDLE_FULL) begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end else begin
                    // A low bit always restarts the idle run; it is only a
                    // start bit if the line was quiet long enough before it.
                    idle_cnt_d = '0;
                    if (idle_cnt_q == IDLE_FULL) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            ST_DATA: begin
                shift_d   = {so_bit, shift_q[15:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                state_d    = ST_IDLE;
                idle_cnt_d = '0;
                if (!so_bit) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    if (shift_q == MAGIC) begin
                        ctrl1_b7_d = 1'b1;
                    end
                end else begin
                    ferr_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                idle_cnt_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_IDLE;
            idle_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= 16'hFFFF;
            data_q     <= 16'hFFFF;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ctrl1_b7_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ctrl1_b7_q <= ctrl1_b7_d;
            busy_q     <= busy_d;
        end
    end

    assign DATA     = data_q;
    assign VALID    = valid_q;
    assign FERR     = ferr_q;
    assign CTRL1_B7 = ctrl1_b7_q;
    assign BUSY     = busy_q;

endmodule

// File: doc/so_receiver.md
SO_RECEIVER -- requirements
Module: so_receiver

Interface
REQ-001 The module SHALL have parameter MAGIC, default 16'h28A0, the unlock word that sets SYSTEM_CTRL1 bit 7.
REQ-002 The module SHALL have parameter MIN_IDLE, default 4, the number of consecutive high samples required before a start bit is accepted.
REQ-003 The module SHALL have port CLK  input  1  the single clock; all SO sampling occurs on the rising edge.
REQ-004 The module SHALL have port RSTn  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port SO  input  1  serial bit-stream from the cartridge mapper, idle high, one bit per CLK.
REQ-006 The module SHALL have port CLR  input  1  synchronous clear of sticky status.
REQ-007 The module SHALL have port DATA  output  16  last received word, LSB received first.
REQ-008 The module SHALL have port VALID  output  1  one-cycle pulse when a frame completes with a correct tail bit.
REQ-009 The module SHALL have port FERR  output  1  one-cycle pulse when a frame tail bit is 1.
REQ-010 The module SHALL have port CTRL1_B7  output  1  sticky SYSTEM_CTRL1 bit 7, set by a valid frame equal to MAGIC.
REQ-011 The module SHALL have port BUSY  output  1  high while a frame is in progress (states DATA and TAIL).

Function
REQ-012 Frame format SHALL be: start bit 0, then 16 data bits LSB-first, then tail bit 0, then idle 1s.
REQ-013 SO sampled as Z or X SHALL be treated as 1, because an external pull-up is present.
REQ-014 The state machine SHALL have states IDLE, DATA, TAIL.
REQ-015 In IDLE, the idle counter (saturating at MIN_IDLE) SHALL increment on SO=1 and clear on SO=0.
REQ-016 IDLE -> DATA SHALL occur on SO=0 only when the idle counter equals MIN_IDLE; otherwise the 0 is ignored and the counter clears.
REQ-017 In DATA, each sample SHALL shift into bit 15 of the shift register, right-shifting; the bit counter SHALL increment 0..15, wrap to 0, and cause the transition to TAIL after the 16th bit.
REQ-018 In TAIL with SO=0: DATA SHALL load the shift register, and VALID SHALL pulse on the next cycle (latency 1 cycle after the tail sample, 18 cycles after the start sample).
REQ-019 In TAIL with SO=1: FERR SHALL pulse on the next cycle, and DATA and CTRL1_B7 SHALL be unchanged.
REQ-020 The TAIL exit SHALL go to IDLE with the idle counter cleared.
REQ-021 CTRL1_B7 SHALL set in the same cycle VALID asserts, if the loaded word equals MAGIC; a non-matching valid word SHALL leave it unchanged.
REQ-022 CLR SHALL clear CTRL1_B7 and SHALL NOT affect DATA or the state machine.
REQ-023 When CLR and a matching VALID coincide, set SHALL win.
REQ-024 CTRL1_B7 and DATA SHALL persist across any number of subsequent frames until reset, CLR, or a new valid frame.

Reset
REQ-025 On RSTn low, the state SHALL be IDLE, the idle counter and bit counter 0, the shift register 16'hFFFF, DATA 16'hFFFF, and VALID, FERR, CTRL1_B7, BUSY all 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no VALID or FERR pulse.
REQ-027 After release from reset, MIN_IDLE high samples SHALL be required before a start is accepted.

Structure
REQ-028 Package bandai2003_pkg SHALL hold the state enum, the MAGIC default (16'h28A0), and the frame length constants (16 data bits, 18 total).
REQ-029 The block SHALL be one module with no sub-modules; the shift register, counters and FSM SHALL be inline.

Verification
REQ-030 A bench SHALL drive a reset release, 4 idle 1s, then the frame {0, 16'h28A0 LSB-first, 0}, and SHALL check: VALID pulse 18 cycles after start, DATA=16'h28A0, CTRL1_B7=1.
REQ-031 A bench SHALL drive the same frame with tail bit 1, and SHALL check: FERR pulse, no VALID, DATA=16'hFFFF, CTRL1_B7=0.
REQ-032 A bench SHALL drive a start bit after only 2 idle 1s, and SHALL check: start ignored, BUSY stays 0, and a later frame with 4 idle 1s decodes normally.
REQ-033 A bench SHALL drive a valid frame with 16'h1234, and SHALL check: VALID pulse, DATA=16'h1234, CTRL1_B7 stays 0.
REQ-034 A bench SHALL assert RSTn low at data bit 8, and SHALL check: no pulses, all outputs at reset values, and a next frame after 4 idle 1s decodes.
REQ-035 A bench SHALL hold CLR high during the VALID cycle of a 16'h28A0 frame, and SHALL check: CTRL1_B7=1; CLR on the following cycle SHALL give CTRL1_B7=0 with DATA still 16'h28A0.
